// File: rtl/data_ram_ws_if.sv
// data_ram_ws_if: MEM-stage data-RAM port bundle (request fields, read data, stall/done status).
// latency: none, wiring only.
// backpressure: responder drives stall_o while an access is outstanding; requester holds its fields stable.
interface data_ram_ws_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        done_o;

  // MEM stage side
  modport master (
    output ce_i, we_i, addr_i, sel_i, data_i,
    input  data_o, stall_o, done_o
  );

  // memory side
  modport slave (
    input  ce_i, we_i, addr_i, sel_i, data_i,
    output data_o, stall_o, done_o
  );
endinterface

// File: rtl/data_ram_ws.sv
// data_ram_ws: word-wide data memory with byte-lane writes and a fixed number of wait states.
// latency: request seen in IDLE at T completes (done_o, data_o valid) at T+WAIT_CYCLES+2.
// backpressure: stall_o = ce_i while IDLE/WAIT; dropping ce_i mid-wait flushes the access.
module data_ram_ws #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2   // 0..15, fits the 4-bit wait counter
) (
  input  logic         clk,
  input  logic         rst,
  data_ram_ws_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  widx_q, widx_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        wdat_q, wdat_d;
  logic [31:0]        data_q, data_d;
  logic               done_q, done_d;
  logic               stall;
  logic               mem_wr;
  logic [31:0]        mem_q [DEPTH];

  // Byte offset and bits above the word index do not select storage (aliasing wrap).
  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};

  // Control, request-latch and read-data state; reset aborts any outstanding access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Latched request fields; only meaningful between an IDLE accept and the access.
  always_ff @(posedge clk) begin
    we_q   <= we_d;
    widx_q <= widx_d;
    sel_q  <= sel_d;
    wdat_q <= wdat_d;
  end

  // Next-state, request capture, access issue and stall generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    widx_d  = widx_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    data_d  = data_q;
    done_d  = 1'b0;
    mem_wr  = 1'b0;
    stall   = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall = bus.ce_i;
        if (bus.ce_i) begin
          we_d    = bus.we_i;
          widx_d  = bus.addr_i[ADDR_W+1:2];
          sel_d   = bus.sel_i;
          wdat_d  = bus.data_i;
          cnt_d   = WAIT_LOAD;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        stall = bus.ce_i;
        if (!bus.ce_i) begin
          // requester withdrew: flush without touching memory or data_o
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (we_q) begin
            mem_wr = ~rst;
          end else begin
            data_d = mem_q[widx_q];
          end
        end
      end

      S_DONE: begin
        // pipeline advances this cycle; any ce_i now is a new request seen next cycle
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Byte-lane write of the latched request on the final wait cycle; storage is never cleared.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (sel_q[k]) begin
          mem_q[widx_q][8*k +: 8] <= wdat_q[8*k +: 8];
        end
      end
    end
  end

  assign bus.data_o  = data_q;
  assign bus.done_o  = done_q;
  assign bus.stall_o = stall;

endmodule
